// File: rtl/axi_read_burst_scheduler.sv
// axi_read_burst_scheduler: splits a linear read command into 4KB-safe AXI INCR bursts with an outstanding-burst limit
module axi_read_burst_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_SIZE_WIDTH       = 32,
  parameter int C_MAX_BURST_LEN    = 16,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_SIZE_WIDTH-1:0]       cmd_size,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic                          busy,
  output logic                          done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                    arlen,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic                          rvalid,
  input  logic                          rready,
  input  logic                          rlast
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int BPW = C_M_AXI_DATA_WIDTH / 8;
  localparam int LG  = $clog2(BPW);
  localparam int SW  = C_SIZE_WIDTH > 13 ? C_SIZE_WIDTH : 13;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0]           cur_addr;
  logic [C_SIZE_WIDTH-1:0] remaining;
  logic [3:0]              outstanding, outstanding_n;
  logic [12:0]             to_boundary;
  logic [SW-1:0]           cap, beats;
  logic                    ar_hs, r_done, last_burst;
  assign to_boundary   = (13'h1000 - {1'b0, cur_addr[11:0]}) >> LG;
  assign cap           = SW'(C_MAX_BURST_LEN) < SW'(to_boundary) ? SW'(C_MAX_BURST_LEN) : SW'(to_boundary);
  assign beats         = SW'(remaining) < cap ? SW'(remaining) : cap;
  assign last_burst    = SW'(remaining) == beats;
  assign arvalid       = state == ISSUE && outstanding < 4'(C_MAX_OUTSTANDING);
  assign araddr        = cur_addr;
  assign arlen         = state == ISSUE ? 8'(beats - SW'(1)) : 8'd0;
  assign ar_hs         = arvalid && arready;
  // rlast with nothing outstanding is a stray beat and must not underflow
  assign r_done        = rvalid && rready && rlast && outstanding != 4'd0;
  assign outstanding_n = outstanding + 4'(ar_hs) - 4'(r_done);
  assign cmd_ready     = state == IDLE && !ARESET;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_n = cmd_size == '0 ? DONE : ISSUE;
      ISSUE:   if (ar_hs && last_burst) state_n = DRAIN;
      DRAIN:   if (outstanding_n == 4'd0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) state <= ARESET ? IDLE : state_n;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cur_addr    <= '0;
      remaining   <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (state == IDLE && cmd_valid) begin
        cur_addr  <= cmd_addr & ~AW'(BPW - 1);
        remaining <= cmd_size;
      end else if (ar_hs) begin
        cur_addr  <= cur_addr + (AW'(beats) << LG);
        remaining <= remaining - C_SIZE_WIDTH'(beats);
      end
    end
  end
endmodule

// File: tb/tb_axi_read_burst_scheduler.sv
// tb_axi_read_burst_scheduler: randomized scoreboard bench for the burst scheduler
module tb_axi_read_burst_scheduler;
  localparam int MAXB = 16;
  localparam int MAXO = 2;
  localparam int BPW  = 4;
  logic        ACLK = 0, ARESET = 1;
  logic [31:0] cmd_addr = '0, cmd_size = '0;
  logic        cmd_valid = 0, cmd_ready, busy, done;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready = 0, rvalid = 0, rready = 0, rlast = 0;
  always #5 ACLK = ~ACLK;
  axi_read_burst_scheduler #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_SIZE_WIDTH(32),
    .C_MAX_BURST_LEN(MAXB), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );
  typedef struct {logic [31:0] a; logic [7:0] l;} burst_t;
  burst_t exp_q[$];
  int     bq[$];
  int     checks = 0, failures = 0, mout = 0, rst_cyc = 0;
  bit     done_exp = 0, idle_exp = 1, cmd_active = 0, r_hold = 0, ar_hold = 0, stray = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 30) $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask
  // reference: walk the command in bursts bounded by remaining, MAXB and the next 4KB line
  function automatic void plan(input logic [31:0] addr, input int unsigned size);
    logic [31:0] a = addr & ~32'(BPW - 1);
    int unsigned rem = size, room, b;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / BPW;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_q.push_back('{a, 8'(b - 1)});
      a = a + 32'(b * BPW);
      rem = rem - b;
    end
  endfunction
  always @(negedge ACLK) begin : mon
    bit inc, dec;
    if (ARESET) begin
      if (rst_cyc > 0) begin
        check("rst_arvalid", arvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
      end
      rst_cyc++;
      exp_q.delete();
      bq.delete();
      mout = 0; done_exp = 0; idle_exp = 1; cmd_active = 0;
    end else begin
      rst_cyc = 0;
      check("done", done, done_exp);
      check("cmd_ready", cmd_ready, idle_exp);
      check("busy", busy, !idle_exp);
      check("arvalid", arvalid, exp_q.size() > 0 && mout < MAXO);
      if (arvalid && exp_q.size() > 0) begin
        check("araddr", araddr, exp_q[0].a);
        check("arlen", arlen, exp_q[0].l);
      end
      inc = arvalid && arready && exp_q.size() > 0;
      dec = rvalid && rready && rlast && mout > 0;
      if (inc) begin
        bq.push_back(int'(exp_q[0].l));
        void'(exp_q.pop_front());
      end
      mout = mout + int'(inc) - int'(dec);
      if (done_exp) idle_exp = 1;
      done_exp = cmd_active && exp_q.size() == 0 && mout == 0;
      if (done_exp) cmd_active = 0;
    end
  end
  initial begin : rdrv
    int left = -1;
    forever begin
      @(posedge ACLK);
      if (ARESET) left = -1;
      else if (rvalid && rready && !stray) left = rlast ? -1 : left - 1;
      #2;
      if (!ARESET && left < 0 && bq.size() > 0) left = bq.pop_front();
      rready  = stray || $urandom_range(0, 3) != 0;
      rvalid  = stray || (left >= 0 && !r_hold && !ARESET && $urandom_range(0, 3) != 0);
      rlast   = stray || left == 0;
      arready = !ar_hold && $urandom_range(0, 3) != 0;
    end
  end
  task automatic do_reset(input int n);
    @(posedge ACLK); #1;
    ARESET = 1;
    cmd_valid = 0;
    repeat (n) @(posedge ACLK);
    #1 ARESET = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    do begin @(negedge ACLK); n++; end while (!done && n < 3000);
    check("done_timeout", n < 3000, 1);
    if (n >= 3000) do_reset(2);
  endtask
  task automatic run_cmd(input logic [31:0] addr, input int unsigned size, input bit wt);
    int n = 0;
    @(posedge ACLK); #1;
    cmd_addr = addr; cmd_size = size; cmd_valid = 1;
    do begin @(negedge ACLK); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge ACLK);
    plan(addr, size);
    idle_exp = 0;
    if (size == 0) done_exp = 1; else cmd_active = 1;
    #1;
    // a held request while busy must be ignored
    if (size >= 20) begin
      cmd_addr = $urandom; cmd_size = $urandom_range(1, 50);
      repeat (3) @(posedge ACLK);
      #1;
    end
    cmd_valid = 0;
    if (wt) wait_done();
  endtask
  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    run_cmd(32'h0, 40, 1);
    run_cmd(32'hFF8, 8, 1);
    run_cmd(32'h1003, 10, 1);
    r_hold = 1;
    run_cmd(32'h100, 64, 0);
    repeat (20) @(posedge ACLK);
    #1 r_hold = 0;
    wait_done();
    ar_hold = 1;
    run_cmd(32'h2000, 40, 0);
    repeat (5) @(posedge ACLK);
    #1 ar_hold = 0;
    wait_done();
    run_cmd(32'h0, 0, 1);
    run_cmd(32'hFFFFFFF0, 16, 1);
    for (int i = 0; i < 25; i++) begin
      int m = $urandom_range(0, 2);
      logic [31:0] a = $urandom;
      if (m == 1) a = a | 32'hF80;
      if (m == 2) a = a | 32'hFFFFF000;
      run_cmd(a, $urandom_range(0, 70), 1);
    end
    r_hold = 1;
    run_cmd(32'h0, 200, 0);
    repeat (10) @(posedge ACLK);
    do_reset(2);
    r_hold = 0;
    @(posedge ACLK); #1 stray = 1;
    repeat (3) @(posedge ACLK);
    #1 stray = 0;
    run_cmd(32'h3000, 40, 1);
    run_cmd(32'hFFC, 3, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
